// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and sizing helpers for the PS/2 keycode receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WAIT_FOR_DATA = 3'd1,
    DATA_IN       = 3'd2,
    PARITY_IN     = 3'd3,
    STOP_IN       = 3'd4
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam int unsigned PS2_BYTE_W = 8;
  localparam int unsigned PS2_CNT_W  = 3;

  function automatic int unsigned ps2_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned ps2_lock_width(input int unsigned cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/ps2_scancode_decoder.sv
// Turns delivered PS/2 bytes into held-key state and one-cycle key events,
// honouring E0/F0 prefixes and a press lockout after each release.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned           NUM_KEYS       = 4,
  parameter logic [8*NUM_KEYS-1:0] KEY_CODES      = {8'h1E, 8'h16, 8'h5A, 8'h29},
  parameter int unsigned           LOCKOUT_CYCLES = 100
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 byte_valid,
  input  logic [PS2_BYTE_W-1:0]                byte_data,
  input  logic                                 byte_error,
  output logic [NUM_KEYS-1:0]                  key_pressed,
  output logic                                 key_event,
  output logic [ps2_idx_width(NUM_KEYS)-1:0]   key_event_idx,
  output logic                                 key_event_release,
  output logic                                 lockout_active
);

  localparam int unsigned IDX_W  = ps2_idx_width(NUM_KEYS);
  localparam int unsigned LOCK_W = ps2_lock_width(LOCKOUT_CYCLES);

  logic              ext_flag, ext_nxt;
  logic              brk_flag, brk_nxt;
  logic [LOCK_W-1:0] lock_cnt, lock_nxt;
  logic [NUM_KEYS-1:0] pressed_nxt;
  logic              event_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic              release_nxt;
  logic              match_hit;
  logic [IDX_W-1:0]  match_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_flag          <= 1'b0;
      brk_flag          <= 1'b0;
      lock_cnt          <= '0;
      key_pressed       <= '0;
      key_event         <= 1'b0;
      key_event_idx     <= '0;
      key_event_release <= 1'b0;
      lockout_active    <= 1'b0;
    end else begin
      ext_flag          <= ext_nxt;
      brk_flag          <= brk_nxt;
      lock_cnt          <= lock_nxt;
      key_pressed       <= pressed_nxt;
      key_event         <= event_nxt;
      key_event_idx     <= idx_nxt;
      key_event_release <= release_nxt;
      lockout_active    <= (lock_nxt != '0);
    end
  end

  // Lowest-index key table match, then prefix/lockout decode rules.
  always_comb begin
    ext_nxt     = ext_flag;
    brk_nxt     = brk_flag;
    pressed_nxt = key_pressed;
    event_nxt   = 1'b0;
    idx_nxt     = key_event_idx;
    release_nxt = key_event_release;
    lock_nxt    = (lock_cnt != '0) ? (lock_cnt - LOCK_W'(1)) : '0;
    match_hit   = 1'b0;
    match_idx   = '0;

    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (!match_hit && (KEY_CODES[8*i +: 8] == byte_data)) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
    end

    if (byte_valid) begin
      if (byte_error) begin
        ext_nxt = 1'b0;
        brk_nxt = 1'b0;
      end else if (byte_data == PS2_EXT) begin
        ext_nxt = 1'b1;
      end else if (byte_data == PS2_BREAK) begin
        brk_nxt = 1'b1;
      end else begin
        ext_nxt = 1'b0;
        brk_nxt = 1'b0;
        if (!ext_flag && match_hit) begin
          if (brk_flag) begin
            if (key_pressed[match_idx]) begin
              pressed_nxt[match_idx] = 1'b0;
              event_nxt              = 1'b1;
              idx_nxt                = match_idx;
              release_nxt            = 1'b1;
              lock_nxt               = LOCK_W'(LOCKOUT_CYCLES);
            end
          end else if (!key_pressed[match_idx] && !lockout_active) begin
            pressed_nxt[match_idx] = 1'b1;
            event_nxt              = 1'b1;
            idx_nxt                = match_idx;
            release_nxt            = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 device-to-host frame receiver with parity/stop checking, feeding a
// scancode decoder that tracks a small table of keys.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned           NUM_KEYS       = 4,
  parameter logic [8*NUM_KEYS-1:0] KEY_CODES      = {8'h1E, 8'h16, 8'h5A, 8'h29},
  parameter int unsigned           LOCKOUT_CYCLES = 100,
  parameter bit                    CHECK_PARITY   = 1'b1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wait_for_incoming_data,
  input  logic                               start_receiving_data,
  input  logic                               ps2_clk_posedge,
  input  logic                               ps2_clk_negedge,
  input  logic                               ps2_data,
  output logic [PS2_BYTE_W-1:0]              received_data,
  output logic                               received_data_en,
  output logic                               parity_error,
  output logic [NUM_KEYS-1:0]                key_pressed,
  output logic                               key_event,
  output logic [ps2_idx_width(NUM_KEYS)-1:0] key_event_idx,
  output logic                               key_event_release,
  output logic                               lockout_active
);

  ps2_state_e            state, state_nxt;
  logic [PS2_BYTE_W-1:0] shift_reg;
  logic [PS2_CNT_W-1:0]  bit_cnt;
  logic                  parity_bit;
  logic                  frame_err_c;
  logic                  unused_negedge;

  assign unused_negedge = ps2_clk_negedge;

  // Odd parity over data+parity, and the stop bit (currently on ps2_data) must be 1.
  assign frame_err_c = CHECK_PARITY & (~(^{shift_reg, parity_bit}) | ~ps2_data);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wait_for_incoming_data && !received_data_en)    state_nxt = WAIT_FOR_DATA;
        else if (start_receiving_data && !received_data_en) state_nxt = DATA_IN;
      end
      WAIT_FOR_DATA: begin
        if (ps2_clk_posedge && !ps2_data) state_nxt = DATA_IN;
        else if (!wait_for_incoming_data) state_nxt = IDLE;
      end
      DATA_IN: begin
        if (ps2_clk_posedge && (bit_cnt == PS2_CNT_W'(7))) state_nxt = PARITY_IN;
      end
      PARITY_IN: begin
        if (ps2_clk_posedge) state_nxt = STOP_IN;
      end
      STOP_IN: begin
        if (ps2_clk_posedge) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath: LSB-first shift, parity capture, one-cycle byte delivery.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg        <= '0;
      bit_cnt          <= '0;
      parity_bit       <= 1'b0;
      received_data    <= '0;
      received_data_en <= 1'b0;
      parity_error     <= 1'b0;
    end else begin
      received_data_en <= 1'b0;
      parity_error     <= 1'b0;
      case (state)
        IDLE, WAIT_FOR_DATA: bit_cnt <= '0;
        DATA_IN: begin
          if (ps2_clk_posedge) begin
            shift_reg <= {ps2_data, shift_reg[PS2_BYTE_W-1:1]};
            bit_cnt   <= bit_cnt + PS2_CNT_W'(1);
          end
        end
        PARITY_IN: begin
          if (ps2_clk_posedge) parity_bit <= ps2_data;
        end
        STOP_IN: begin
          if (ps2_clk_posedge) begin
            received_data    <= shift_reg;
            received_data_en <= 1'b1;
            parity_error     <= frame_err_c;
          end
        end
        default: bit_cnt <= '0;
      endcase
    end
  end

  ps2_scancode_decoder #(
    .NUM_KEYS       (NUM_KEYS),
    .KEY_CODES      (KEY_CODES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) u_decoder (
    .clk               (clk),
    .reset             (reset),
    .byte_valid        (received_data_en),
    .byte_data         (received_data),
    .byte_error        (parity_error),
    .key_pressed       (key_pressed),
    .key_event         (key_event),
    .key_event_idx     (key_event_idx),
    .key_event_release (key_event_release),
    .lockout_active    (lockout_active)
  );

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: directed and random PS/2 frames, checked every cycle
// against a byte-level key model.
module tb_ps2_keycode_rx;

  localparam int NK   = 4;
  localparam int LOCK = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wait_for_incoming_data = 1'b0;
  logic       start_receiving_data = 1'b0;
  logic       ps2_clk_posedge = 1'b0;
  logic       ps2_clk_negedge = 1'b0;
  logic       ps2_data = 1'b1;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       parity_error;
  logic [NK-1:0] key_pressed;
  logic       key_event;
  logic [1:0] key_event_idx;
  logic       key_event_release;
  logic       lockout_active;

  ps2_keycode_rx dut (
    .clk                    (clk),
    .reset                  (reset),
    .wait_for_incoming_data (wait_for_incoming_data),
    .start_receiving_data   (start_receiving_data),
    .ps2_clk_posedge        (ps2_clk_posedge),
    .ps2_clk_negedge        (ps2_clk_negedge),
    .ps2_data               (ps2_data),
    .received_data          (received_data),
    .received_data_en       (received_data_en),
    .parity_error           (parity_error),
    .key_pressed            (key_pressed),
    .key_event              (key_event),
    .key_event_idx          (key_event_idx),
    .key_event_release      (key_event_release),
    .lockout_active         (lockout_active)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic rst_q = 1'b1;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  // Key table: index 0 is the low byte of the packed make-code parameter.
  logic [7:0] codes [NK] = '{8'h29, 8'h5A, 8'h16, 8'h1E};

  // Model state
  bit            dv_pending = 1'b0;
  int            deliv_cycle = 0;
  logic [7:0]    deliv_byte = 8'h00;
  bit            deliv_err = 1'b0;
  logic [NK-1:0] m_pressed = '0;
  logic [7:0]    m_data = 8'h00;
  bit            m_ext = 1'b0;
  bit            m_brk = 1'b0;
  bit            has_rel = 1'b0;
  int            rel_cyc = 0;
  int            pend_cycle = -1;
  logic [NK-1:0] pend_pressed = '0;
  int            pend_idx = 0;
  bit            pend_rel = 1'b0;
  bit            e_en, e_perr, e_ev, e_lock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_decode(input logic [7:0] b, input bit err);
    int hit;
    bit locked;
    hit    = -1;
    locked = has_rel && (cyc <= rel_cyc + LOCK);
    if (err) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      for (int i = 0; i < NK; i++)
        if (hit < 0 && codes[i] == b) hit = i;
      if (!m_ext && hit >= 0) begin
        if (m_brk && m_pressed[hit]) begin
          pend_pressed      = m_pressed;
          pend_pressed[hit] = 1'b0;
          pend_idx          = hit;
          pend_rel          = 1'b1;
          pend_cycle        = cyc + 1;
          has_rel           = 1'b1;
          rel_cyc           = cyc;
        end else if (!m_brk && !m_pressed[hit] && !locked) begin
          pend_pressed      = m_pressed;
          pend_pressed[hit] = 1'b1;
          pend_idx          = hit;
          pend_rel          = 1'b0;
          pend_cycle        = cyc + 1;
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    e_en   = 1'b0;
    e_perr = 1'b0;
    e_ev   = 1'b0;
    if (rst_q) begin
      m_pressed  = '0;
      m_data     = 8'h00;
      m_ext      = 1'b0;
      m_brk      = 1'b0;
      has_rel    = 1'b0;
      dv_pending = 1'b0;
      pend_cycle = -1;
    end else begin
      if (pend_cycle == cyc) begin
        m_pressed = pend_pressed;
        e_ev      = 1'b1;
      end
      if (dv_pending && deliv_cycle == cyc) begin
        dv_pending = 1'b0;
        e_en       = 1'b1;
        m_data     = deliv_byte;
        e_perr     = deliv_err;
      end
    end
    e_lock = has_rel && (cyc > rel_cyc) && (cyc <= rel_cyc + LOCK);
    chk("received_data", 32'(received_data), 32'(m_data));
    chk("received_data_en", 32'(received_data_en), 32'(e_en));
    chk("parity_error", 32'(parity_error), 32'(e_perr));
    chk("key_pressed", 32'(key_pressed), 32'(m_pressed));
    chk("key_event", 32'(key_event), 32'(e_ev));
    chk("lockout_active", 32'(lockout_active), 32'(e_lock));
    if (e_ev) begin
      chk("key_event_idx", 32'(key_event_idx), 32'(pend_idx));
      chk("key_event_release", 32'(key_event_release), 32'(pend_rel));
    end
    if (e_en) model_decode(m_data, e_perr);
  end

  task automatic strobe(input logic d, input int gap);
    @(posedge clk); #1;
    ps2_data        = d;
    ps2_clk_posedge = 1'b1;
    @(posedge clk); #1;
    ps2_clk_posedge = 1'b0;
    ps2_data        = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit use_wait, input int gap, input int pre);
    logic par;
    par = ~(^b) ^ bad_par;
    if (use_wait) begin
      @(posedge clk); #1;
      wait_for_incoming_data = 1'b1;
      repeat (pre) strobe(1'b1, gap);
      strobe(1'b0, gap);
      wait_for_incoming_data = 1'b0;
    end else begin
      @(posedge clk); #1;
      start_receiving_data = 1'b1;
      @(posedge clk); #1;
      start_receiving_data = 1'b0;
    end
    for (int i = 0; i < 8; i++) strobe(b[i], gap);
    strobe(par, gap);
    @(posedge clk); #1;
    ps2_data        = ~bad_stop;
    ps2_clk_posedge = 1'b1;
    deliv_byte      = b;
    deliv_err       = bad_par | bad_stop;
    deliv_cycle     = cyc + 1;
    dv_pending      = 1'b1;
    @(posedge clk); #1;
    ps2_clk_posedge = 1'b0;
    ps2_data        = 1'b1;
    repeat (gap + 2) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b1, 1, 0);
  endtask

  task automatic lit(input string name, input logic [NK-1:0] exp);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({name, " dut"}, 32'(key_pressed), 32'(exp));
    chk({name, " model"}, 32'(m_pressed), 32'(exp));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rb;
    int         r;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset received_data", 32'(received_data), 32'h0);
    chk("reset lockout_active", 32'(lockout_active), 32'h0);

    send(8'h29);
    lit("press 29", 4'b0001);
    chk("byte 29", 32'(received_data), 32'h29);

    send(8'hF0); send(8'h29);
    lit("release 29", 4'b0000);
    chk("lockout after release", 32'(lockout_active), 32'h1);
    send(8'h29);
    lit("press in lockout", 4'b0000);
    repeat (120) @(posedge clk);
    send(8'h29);
    lit("press after lockout", 4'b0001);

    send(8'hE0); send(8'h5A);
    lit("extended 5A", 4'b0001);
    send(8'h5A);
    lit("plain 5A", 4'b0011);

    send_frame(8'h16, 1'b1, 1'b0, 1'b0, 1, 0);
    lit("bad parity 16", 4'b0011);
    chk("bad parity byte", 32'(received_data), 32'h16);
    send(8'hF0);
    send_frame(8'h16, 1'b0, 1'b1, 1'b1, 1, 0);
    send(8'h16);
    lit("brk cleared by error", 4'b0111);

    for (int k = 0; k < 4; k++) send(8'h1E);
    lit("typematic 1E", 4'b1111);

    @(posedge clk); #1 start_receiving_data = 1'b1;
    @(posedge clk); #1 start_receiving_data = 1'b0;
    for (int k = 0; k < 4; k++) strobe(1'($urandom_range(0, 1)), 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    lit("after mid-frame reset", 4'b0000);
    chk("reset mid-frame data", 32'(received_data), 32'h0);
    send(8'h29);
    lit("frame after reset", 4'b0001);

    for (int n = 0; n < 120; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)       rb = codes[r];
      else if (r < 6)  rb = 8'hF0;
      else if (r == 6) rb = 8'hE0;
      else             rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk); #1 wait_for_incoming_data = 1'b1;
        repeat (3) @(posedge clk);
        #1 wait_for_incoming_data = 1'b0;
        repeat (2) @(posedge clk);
      end
      send_frame(rb, ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 2)));
      repeat ($urandom_range(2, 70)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("no frame left undelivered", 32'(dv_pending), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
